// File: rtl/vrf_sb.sv
// Vector register file: multi-port combinational reads, byte-enabled lane writes with optional
// write-to-read bypass, per-register busy scoreboard and a sequential whole-vector clear engine.
module vrf_sb #(
    parameter int unsigned els_p    = 32,
    parameter int unsigned vlen_p   = 8,
    parameter int unsigned vdw_p    = 32,
    parameter int unsigned lanes_p  = 4,
    parameter int unsigned rports_p = 3,
    parameter int unsigned bypass_p = 1
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic [rports_p-1:0][$clog2(els_p)-1:0]       r_reg_addr_i,
    input  logic [lanes_p-1:0][$clog2(vlen_p)-1:0]       r_addr_i,
    output logic [rports_p-1:0][lanes_p-1:0][vdw_p-1:0]  r_data_o,
    input  logic [$clog2(els_p)-1:0]                     w_reg_addr_i,
    input  logic [lanes_p-1:0][$clog2(vlen_p)-1:0]       w_addr_i,
    input  logic [lanes_p-1:0][vdw_p-1:0]                w_data_i,
    input  logic [lanes_p-1:0][vdw_p/8-1:0]              w_be_i,
    input  logic [lanes_p-1:0]                           w_en_i,
    input  logic                                         rsv_v_i,
    input  logic [$clog2(els_p)-1:0]                     rsv_reg_i,
    output logic                                         rsv_ready_o,
    input  logic                                         rel_v_i,
    input  logic [$clog2(els_p)-1:0]                     rel_reg_i,
    output logic [els_p-1:0]                             busy_o,
    input  logic                                         clr_v_i,
    input  logic [$clog2(els_p)-1:0]                     clr_reg_i,
    output logic                                         clr_ready_o,
    output logic                                         clr_done_o
);

    localparam int unsigned RegW  = $clog2(els_p);
    localparam int unsigned EaW   = $clog2(vlen_p);
    localparam int unsigned BeW   = vdw_p / 8;
    localparam int unsigned Beats = vlen_p / lanes_p;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RegW-1:0]   clr_reg_q, clr_reg_d;
    logic [els_p-1:0]  busy_q, busy_d;
    logic [vdw_p-1:0]  mem_q [els_p][vlen_p];

    logic                          clr_acc;
    logic                          clr_wr;
    logic                          owned;
    logic                          rel_eff;
    logic [lanes_p-1:0]            ext_we;
    logic [lanes_p-1:0][EaW-1:0]   clr_el;

    assign clr_wr = (state_q == StClear);
    assign busy_o = busy_q;

    // The clear engine owns every lane while it targets the register the external port writes.
    always_comb begin
        ext_we = '0;
        clr_el = '0;
        for (int l = 0; l < lanes_p; l++) begin
            ext_we[l] = w_en_i[l] & ~(clr_wr & (w_reg_addr_i == clr_reg_q));
            clr_el[l] = EaW'(32'(cnt_q) * lanes_p + 32'(l));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_reg_d   = clr_reg_q;
        clr_ready_o = 1'b0;
        clr_done_o  = 1'b0;
        clr_acc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                clr_ready_o = ~busy_q[clr_reg_i];
                if (clr_v_i && !busy_q[clr_reg_i]) begin
                    clr_acc   = 1'b1;
                    clr_reg_d = clr_reg_i;
                    cnt_d     = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(Beats - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                clr_done_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        owned       = (state_q != StIdle) && (rel_reg_i == clr_reg_q);
        rel_eff     = rel_v_i & busy_q[rel_reg_i] & ~owned;
        rsv_ready_o = (~busy_q[rsv_reg_i] | (rel_eff & (rel_reg_i == rsv_reg_i)))
                      & ~(clr_acc & (clr_reg_i == rsv_reg_i));
        busy_d = busy_q;
        if (rel_eff) busy_d[rel_reg_i] = 1'b0;
        if (state_q == StDone) busy_d[clr_reg_q] = 1'b0;
        if (clr_acc) busy_d[clr_reg_i] = 1'b1;
        // Applied after the release so a same-cycle release+reserve hands the register over.
        if (rsv_v_i && rsv_ready_o) busy_d[rsv_reg_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            clr_reg_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_reg_q <= clr_reg_d;
            busy_q    <= busy_d;
        end
    end

    // Later lanes issue their non-blocking writes last, so the higher lane wins per byte.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                for (int j = 0; j < vlen_p; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            for (int l = 0; l < lanes_p; l++) begin
                for (int b = 0; b < BeW; b++) begin
                    if (ext_we[l] && w_be_i[l][b]) begin
                        mem_q[w_reg_addr_i][w_addr_i[l]][8*b +: 8] <= w_data_i[l][8*b +: 8];
                    end
                end
            end
            if (clr_wr) begin
                for (int l = 0; l < lanes_p; l++) begin
                    mem_q[clr_reg_q][clr_el[l]] <= '0;
                end
            end
        end
    end

    always_comb begin
        r_data_o = '0;
        for (int p = 0; p < rports_p; p++) begin
            for (int l = 0; l < lanes_p; l++) begin
                r_data_o[p][l] = mem_q[r_reg_addr_i[p]][r_addr_i[l]];
                if (bypass_p != 0) begin
                    if (ext_we[l] && (w_reg_addr_i == r_reg_addr_i[p])
                        && (w_addr_i[l] == r_addr_i[l])) begin
                        for (int b = 0; b < BeW; b++) begin
                            if (w_be_i[l][b]) r_data_o[p][l][8*b +: 8] = w_data_i[l][8*b +: 8];
                        end
                    end
                    if (clr_wr && (clr_reg_q == r_reg_addr_i[p]) && (clr_el[l] == r_addr_i[l])) begin
                        r_data_o[p][l] = '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vrf_sb.sv
// Directed bench for vrf_sb: stimulus queues expected outputs, a negedge monitor compares them.
module tb_vrf_sb;

    localparam int unsigned RP    = 3;
    localparam int unsigned LANES = 4;

    logic                             clk;
    logic                             reset_n;
    logic [RP-1:0][4:0]               r_reg_addr;
    logic [LANES-1:0][2:0]            r_addr;
    logic [RP-1:0][LANES-1:0][31:0]   r_data;
    logic [4:0]                       w_reg_addr;
    logic [LANES-1:0][2:0]            w_addr;
    logic [LANES-1:0][31:0]           w_data;
    logic [LANES-1:0][3:0]            w_be;
    logic [LANES-1:0]                 w_en;
    logic                             rsv_v;
    logic [4:0]                       rsv_reg;
    logic                             rsv_ready;
    logic                             rel_v;
    logic [4:0]                       rel_reg;
    logic [31:0]                      busy;
    logic                             clr_v;
    logic [4:0]                       clr_reg;
    logic                             clr_ready;
    logic                             clr_done;

    vrf_sb #(
        .els_p(32), .vlen_p(8), .vdw_p(32), .lanes_p(4), .rports_p(3), .bypass_p(1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .r_reg_addr_i(r_reg_addr), .r_addr_i(r_addr), .r_data_o(r_data),
        .w_reg_addr_i(w_reg_addr), .w_addr_i(w_addr), .w_data_i(w_data),
        .w_be_i(w_be), .w_en_i(w_en),
        .rsv_v_i(rsv_v), .rsv_reg_i(rsv_reg), .rsv_ready_o(rsv_ready),
        .rel_v_i(rel_v), .rel_reg_i(rel_reg), .busy_o(busy),
        .clr_v_i(clr_v), .clr_reg_i(clr_reg), .clr_ready_o(clr_ready), .clr_done_o(clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          kind;  // 0 r_data[p][l], 1 busy, 2 rsv_ready, 3 clr_ready, 4 clr_done
        int          p;
        int          l;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(int kind, int p, int l);
        case (kind)
            0:       return r_data[p][l];
            1:       return busy;
            2:       return {31'b0, rsv_ready};
            3:       return {31'b0, clr_ready};
            default: return {31'b0, clr_done};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.kind, e.p, e.l);
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.nm, a, e.exp);
            end
        end
    end

    initial begin : watchdog
        #20000;
        errors++;
        $display("FAIL timeout: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic chk(input string nm, input int kind, input int p, input int l,
                       input logic [31:0] v);
        exp_t e;
        e.nm = nm; e.kind = kind; e.p = p; e.l = l; e.exp = v;
        q.push_back(e);
    endtask

    task automatic chk_now(input string nm, input int kind, input int p, input int l,
                           input logic [31:0] v);
        logic [31:0] a;
        a = actual(kind, p, l);
        checks++;
        if (a !== v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input int base);
        for (int l = 0; l < LANES; l++) r_addr[l] = 3'(base + l);
    endtask

    task automatic set_waddr(input int base);
        for (int l = 0; l < LANES; l++) w_addr[l] = 3'(base + l);
    endtask

    initial begin
        reset_n = 1'b0;
        r_reg_addr = '0; r_addr = '0;
        w_reg_addr = '0; w_addr = '0; w_data = '0; w_be = '0; w_en = '0;
        rsv_v = 1'b0; rsv_reg = '0; rel_v = 1'b0; rel_reg = '0;
        clr_v = 1'b0; clr_reg = '0;
        #2;
        chk_now("in_rst_busy", 1, 0, 0, 32'h0);
        chk_now("in_rst_done", 4, 0, 0, 32'h0);
        chk_now("in_rst_rdata0", 0, 0, 0, 32'h0);
        chk_now("in_rst_rdata3", 0, 0, 3, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        r_reg_addr[0] = 5'd0; r_reg_addr[1] = 5'd31; r_reg_addr[2] = 5'd0;
        set_raddr(0);
        for (int p = 0; p < RP; p++)
            for (int l = 0; l < LANES; l++) chk("rst_rdata", 0, p, l, 32'h0);
        chk("rst_busy", 1, 0, 0, 32'h0);
        chk("rst_rsv_ready", 2, 0, 0, 32'h1);
        chk("rst_clr_ready", 3, 0, 0, 32'h1);
        chk("rst_clr_done", 4, 0, 0, 32'h0);

        // Full write to reg 5 elements 4-7, bypassed then stored
        cyc();
        w_reg_addr = 5'd5; set_waddr(4); w_en = 4'hF;
        for (int l = 0; l < LANES; l++) begin
            w_data[l] = 32'hA0A0A0A0 + 32'(l);
            w_be[l] = 4'hF;
        end
        r_reg_addr[2] = 5'd5; set_raddr(4);
        for (int l = 0; l < LANES; l++) chk("byp_full", 0, 2, l, 32'hA0A0A0A0 + 32'(l));
        cyc();
        w_en = '0;
        for (int l = 0; l < LANES; l++) chk("wr_reg5", 0, 2, l, 32'hA0A0A0A0 + 32'(l));

        // Byte-enabled partial write
        cyc();
        w_en = 4'b0001; w_data[0] = 32'hFFFFFFFF; w_be[0] = 4'h3;
        chk("byp_be", 0, 2, 0, 32'hA0A0FFFF);
        cyc();
        w_en = '0;
        chk("be_merge", 0, 2, 0, 32'hA0A0FFFF);
        chk("be_other", 0, 2, 1, 32'hA0A0A0A1);

        // Lanes 0 and 1 both hit element 6: higher lane wins per byte; bypass is per lane
        cyc();
        w_addr[0] = 3'd6; w_addr[1] = 3'd6;
        w_data[0] = 32'h11111111; w_be[0] = 4'hF;
        w_data[1] = 32'h22222222; w_be[1] = 4'h3;
        w_en = 4'b0011;
        chk("byp_per_lane", 0, 2, 2, 32'hA0A0A0A2);
        cyc();
        w_en = '0;
        chk("lane_prio", 0, 2, 2, 32'h11112222);

        // Fill reg 7 then clear it
        cyc();
        w_reg_addr = 5'd7; set_waddr(0); w_en = 4'hF;
        for (int l = 0; l < LANES; l++) begin
            w_data[l] = 32'h70000000 + 32'(l);
            w_be[l] = 4'hF;
        end
        cyc();
        set_waddr(4);
        for (int l = 0; l < LANES; l++) w_data[l] = 32'h70000004 + 32'(l);
        cyc();
        w_en = '0; clr_v = 1'b1; clr_reg = 5'd7; rsv_reg = 5'd7;
        r_reg_addr[0] = 5'd7; set_raddr(0);
        chk("clr_ready_idle", 3, 0, 0, 32'h1);
        chk("rsv_vs_clr", 2, 0, 0, 32'h0);
        chk("fill7_l0", 0, 0, 0, 32'h70000000);
        chk("fill7_l3", 0, 0, 3, 32'h70000003);
        cyc();  // CLEAR beat 0
        clr_v = 1'b0; rel_v = 1'b1; rel_reg = 5'd7;
        chk("clr1_busy", 1, 0, 0, 32'h00000080);
        chk("clr1_ready", 3, 0, 0, 32'h0);
        chk("clr1_done", 4, 0, 0, 32'h0);
        chk("clr1_rsv_ready", 2, 0, 0, 32'h0);
        chk("clr1_byp", 0, 0, 1, 32'h0);
        cyc();  // CLEAR beat 1
        rel_v = 1'b0; set_raddr(4);
        chk("rel_ignored", 1, 0, 0, 32'h00000080);
        chk("clr2_done", 4, 0, 0, 32'h0);
        chk("clr2_byp", 0, 0, 2, 32'h0);
        cyc();  // DONE
        chk("clr_done_pulse", 4, 0, 0, 32'h1);
        chk("done_busy", 1, 0, 0, 32'h00000080);
        chk("done_ready", 3, 0, 0, 32'h0);
        cyc();
        chk("post_done", 4, 0, 0, 32'h0);
        chk("post_busy", 1, 0, 0, 32'h0);
        chk("post_ready", 3, 0, 0, 32'h1);
        for (int l = 0; l < LANES; l++) chk("cleared_hi", 0, 0, l, 32'h0);
        cyc();
        set_raddr(0);
        for (int l = 0; l < LANES; l++) chk("cleared_lo", 0, 0, l, 32'h0);

        // Clear refused while reserved
        cyc();
        rsv_v = 1'b1; rsv_reg = 5'd7;
        chk("rsv7_ready", 2, 0, 0, 32'h1);
        cyc();
        rsv_v = 1'b0; clr_v = 1'b1; clr_reg = 5'd7;
        chk("clr_blocked", 3, 0, 0, 32'h0);
        chk("rsv7_busy", 1, 0, 0, 32'h00000080);
        cyc();
        clr_v = 1'b0; clr_reg = 5'd8; rel_v = 1'b1; rel_reg = 5'd7;
        chk("no_clr_start", 3, 0, 0, 32'h1);
        chk("no_clr_busy", 1, 0, 0, 32'h00000080);
        cyc();
        rel_v = 1'b0;
        chk("rel7", 1, 0, 0, 32'h0);

        // Reserve / handoff / release of reg 3
        cyc();
        rsv_v = 1'b1; rsv_reg = 5'd3;
        chk("rsv3_ready", 2, 0, 0, 32'h1);
        cyc();
        rel_v = 1'b1; rel_reg = 5'd3;
        chk("handoff_ready", 2, 0, 0, 32'h1);
        chk("rsv3_busy", 1, 0, 0, 32'h00000008);
        cyc();
        rsv_v = 1'b0;
        chk("handoff_busy", 1, 0, 0, 32'h00000008);
        cyc();
        rel_v = 1'b0;
        chk("rel3_busy", 1, 0, 0, 32'h0);

        // Reset in the middle of a clear
        cyc();
        clr_v = 1'b1; clr_reg = 5'd9;
        cyc();
        clr_v = 1'b0;
        chk("clr9_busy", 1, 0, 0, 32'h00000200);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 1, 0, 0, 32'h0);
        chk("rst_mid_done", 4, 0, 0, 32'h0);
        chk_now("rst_mid_busy_now", 1, 0, 0, 32'h0);
        chk_now("rst_mid_done_now", 4, 0, 0, 32'h0);
        cyc();
        chk("rst_hold_done", 4, 0, 0, 32'h0);
        cyc();
        reset_n = 1'b1;
        r_reg_addr[2] = 5'd5; set_raddr(4);
        chk("after_rst_ready", 3, 0, 0, 32'h1);
        chk("after_rst_busy", 1, 0, 0, 32'h0);
        chk("after_rst_done", 4, 0, 0, 32'h0);
        chk("after_rst_mem", 0, 2, 1, 32'h0);
        cyc();
        chk("idle_done", 4, 0, 0, 32'h0);
        cyc();
        cyc();

        if (errors == 0) $display("PASS");
        else $display("FAIL: %0d errors", errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
